// File: rtl/homomorphic_multiply.sv
// homomorphic_multiply
//   Coefficient-streaming ciphertext polynomial multiplier (LWE/BFV datapath).
//   Ciphertext A (DIMENSION+1 coefficients) is buffered first. Ciphertext B then
//   streams in one coefficient per cycle, and all DIMENSION+1 multiply-accumulates
//   for that coefficient happen in the same cycle. The 2*DIMENSION+1 product
//   coefficients (no negacyclic wrap) are reduced mod q. c[0..D] appear during
//   streaming; c[D+1..2D] are read out afterwards.
//
// Ports
//   clk               rising-edge clock
//   rst_n             synchronous reset, ACTIVE-HIGH (legacy name)
//   ciphertext_entry  signed coefficient in, CIPHERTEXT_WIDTH bits
//   row               coefficient index 0..2*DIMENSION
//   ciphertext_select 0 = load A / read out, 1 = stream B
//   en                cycle qualifier; 0 holds all state
//   result_partial    registered product coefficient (non-negative residue)
//
// Optional feature macro: HOMOMORPHIC_MULTIPLY_SCALE_EN
//   When defined, every value driven onto result_partial is rescaled to the
//   plaintext domain as round(c*t/q) mod t, rounding half up. The accumulators
//   stay unscaled.
module homomorphic_multiply #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 21,
  parameter int DIMENSION          = 3,
  parameter int BIG_N              = 30
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CIPHERTEXT_WIDTH-1:0] ciphertext_entry,
  input  logic [DIMENSION:0]          row,
  input  logic                        ciphertext_select,
  input  logic                        en,
  output logic [CIPHERTEXT_WIDTH-1:0] result_partial
);

  localparam int W  = CIPHERTEXT_WIDTH;
  localparam int D  = DIMENSION;
  // Signed working width: one bit above a full 2W-bit product, so sums of an
  // unsigned residue and a product can never look negative.
  localparam int PW = 2*W + 1;

  typedef logic signed [PW-1:0] wide_t;

  localparam wide_t Q_W    = wide_t'(CIPHERTEXT_MODULUS);
  localparam bit    Q_POW2 = ((CIPHERTEXT_MODULUS & (CIPHERTEXT_MODULUS - 1)) == 0);

  // Reduce to [0, q-1]. A power-of-two q is a plain mask, which is also correct
  // for negative two's-complement values. Any other q uses a true modulo with a
  // fix-up, because % keeps the sign of the dividend.
  function automatic logic [W-1:0] mod_q(input wide_t v);
    wide_t r;
    if (Q_POW2) begin
      r = v & (Q_W - wide_t'(1));
    end else begin
      r = v % Q_W;
      if (r < 0) r = r + Q_W;
    end
    return W'(r);
  endfunction

  function automatic wide_t widen(input logic [W-1:0] u);
    return wide_t'({{(PW-W){1'b0}}, u});
  endfunction

`ifdef HOMOMORPHIC_MULTIPLY_SCALE_EN
  function automatic logic [W-1:0] scale(input logic [W-1:0] c);
    wide_t s;
    s = (widen(c) * wide_t'(PLAINTEXT_MODULUS) + (Q_W >>> 1)) / Q_W;
    s = s % wide_t'(PLAINTEXT_MODULUS);
    return W'(s);
  endfunction
`endif

  // These parameters belong to the surrounding scheme and do not affect this block.
  logic unused_cfg;
  assign unused_cfg = ^{32'(BIG_N), 32'(PLAINTEXT_WIDTH), 32'(PLAINTEXT_MODULUS)};

  logic [W-1:0] a_buf_reg  [0:D];
  logic [W-1:0] a_buf_next [0:D];
  logic [W-1:0] acc_reg    [0:2*D];
  logic [W-1:0] acc_next   [0:2*D];
  logic [W-1:0] result_reg;
  logic [W-1:0] result_next;
  logic [W-1:0] x;
  wide_t        prod [0:D];
  int           row_idx;
  logic [W-1:0] raw;
  logic         drive;

  // Sign-extend the input coefficient, then fold it into [0, q-1].
  assign x = mod_q(wide_t'({{(PW-W){ciphertext_entry[W-1]}}, ciphertext_entry}));

  // One full-width multiplier per A coefficient, so every MAC completes in a single cycle.
  generate
    for (genvar gi = 0; gi <= D; gi++) begin : g_mul
      assign prod[gi] = widen(a_buf_reg[gi]) * widen(x);
    end
  endgenerate

  always_comb begin
    a_buf_next  = a_buf_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    raw         = '0;
    drive       = 1'b0;
    row_idx     = int'(row);
    if (en) begin
      if (!ciphertext_select) begin
        if (row_idx <= D) begin
          a_buf_next[row_idx] = x;
          // Loading A[0] marks the start of a new product.
          if (row_idx == 0) begin
            for (int k = 0; k <= 2*D; k++) acc_next[k] = '0;
          end
        end else if (row_idx <= 2*D) begin
          raw   = acc_reg[row_idx];
          drive = 1'b1;
        end else begin
          raw   = '0;
          drive = 1'b1;
        end
      end else if (row_idx <= D) begin
        for (int j = 0; j <= D; j++) begin
          acc_next[row_idx + j] = mod_q(widen(acc_reg[row_idx + j]) + prod[j]);
        end
        // c[row] receives its last contribution now, so it is final.
        raw   = acc_next[row_idx];
        drive = 1'b1;
      end
    end
    if (drive) begin
`ifdef HOMOMORPHIC_MULTIPLY_SCALE_EN
      result_next = scale(raw);
`else
      result_next = raw;
`endif
    end
  end

  generate
    for (genvar gi = 0; gi <= D; gi++) begin : g_a_buf
      always_ff @(posedge clk) begin
        if (rst_n) a_buf_reg[gi] <= '0;
        else       a_buf_reg[gi] <= a_buf_next[gi];
      end
    end
    for (genvar gi = 0; gi <= 2*D; gi++) begin : g_acc
      always_ff @(posedge clk) begin
        if (rst_n) acc_reg[gi] <= '0;
        else       acc_reg[gi] <= acc_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst_n) result_reg <= '0;
    else       result_reg <= result_next;
  end

  assign result_partial = result_reg;

endmodule

// File: tb/tb_homomorphic_multiply.sv
// tb_homomorphic_multiply
//   Scoreboard bench for homomorphic_multiply. Each driven cycle pushes the value
//   result_partial must show after the next rising edge. A monitor pops and
//   compares on falling edges. Expected coefficients are hand-derived polynomial
//   products. They are rescaled here when HOMOMORPHIC_MULTIPLY_SCALE_EN is defined.
module tb_homomorphic_multiply;
  localparam int W = 21;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel;
  logic         en;
  logic [W-1:0] entry;
  logic [D:0]   row;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int           due;
    logic [W-1:0] val;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_exp;

  homomorphic_multiply dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ciphertext_entry  (entry),
    .row               (row),
    .ciphertext_select (sel),
    .en                (en),
    .result_partial    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic logic [W-1:0] scaled(input int raw);
`ifdef HOMOMORPHIC_MULTIPLY_SCALE_EN
    return W'(((raw * 64 + 512) / 1024) % 64);
`else
    return W'(raw);
`endif
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      check_val(sb[0].tag, result, sb[0].val);
      void'(sb.pop_front());
    end
  end

  task automatic drive(input logic r, input logic e, input logic s, input int ent, input int rw);
    @(negedge clk);
    rst_n = r;
    en    = e;
    sel   = s;
    entry = W'(ent);
    row   = (D+1)'(rw);
  endtask

  task automatic push(input string tag, input logic [W-1:0] v);
    exp_t e;
    e.due = cyc + 1;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
    last_exp = v;
  endtask

  task automatic load_a(input string name, input int a[4]);
    for (int r = 0; r <= D; r++) begin
      drive(1'b0, 1'b1, 1'b0, a[r], r);
      push($sformatf("%s loadA r%0d hold", name, r), last_exp);
    end
  endtask

  task automatic stream_b(input string name, input int b[4], input int c[7]);
    for (int r = 0; r <= D; r++) begin
      drive(1'b0, 1'b1, 1'b1, b[r], r);
      push($sformatf("%s c%0d", name, r), scaled(c[r]));
    end
    for (int r = D + 1; r <= 2*D; r++) begin
      drive(1'b0, 1'b1, 1'b0, 0, r);
      push($sformatf("%s read c%0d", name, r), scaled(c[r]));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; sel = 1'b0; entry = '0; row = '0; last_exp = '0;

    // Reset for 10 cycles; the last one also tries a stream op to show reset wins over en.
    repeat (9) drive(1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 5, 0);
    push("reset", '0);
    repeat (3) begin
      drive(1'b0, 1'b0, 1'b0, 0, 0);
      push("idle after reset", '0);
    end

    load_a("ones", '{1, 1, 1, 1});
    stream_b("ones", '{1, 1, 1, 1}, '{1, 2, 3, 4, 3, 2, 1});

    // Boundary handling of row/select/en.
    drive(1'b0, 1'b1, 1'b0, 0, 7);
    push("row>2D read", '0);
    drive(1'b0, 1'b1, 1'b1, 9, 4);
    push("stream row>D hold", last_exp);
    drive(1'b0, 1'b0, 1'b1, 9, 0);
    push("en=0 hold", last_exp);
    drive(1'b0, 1'b1, 0, 0, 5);
    push("acc untouched c5", scaled(2));

    load_a("mix", '{2, 0, 0, 3});
    stream_b("mix", '{5, 1, 0, 0}, '{10, 2, 0, 15, 3, 0, 0});

    // Reloading A[0] clears the accumulators; product must not inherit "mix".
    load_a("reload", '{1, 1, 1, 1});
    stream_b("reload", '{1, 1, 1, 1}, '{1, 2, 3, 4, 3, 2, 1});

    load_a("wrap1", '{1000, 0, 0, 0});
    stream_b("wrap1", '{2, 0, 0, 0}, '{976, 0, 0, 0, 0, 0, 0});
    load_a("wrap2", '{-1, 0, 0, 0});
    stream_b("wrap2", '{1, 0, 0, 0}, '{1023, 0, 0, 0, 0, 0, 0});

    // Abort mid-stream with reset.
    load_a("abort", '{1, 1, 1, 1});
    drive(1'b0, 1'b1, 1'b1, 1, 0);
    push("abort c0", scaled(1));
    drive(1'b0, 1'b1, 1'b1, 1, 1);
    push("abort c1", scaled(2));
    drive(1'b1, 1'b1, 1'b1, 1, 2);
    push("midstream reset", '0);
    // A was cleared by reset, so streaming B alone yields all zeros.
    stream_b("cleared", '{1, 1, 1, 1}, '{0, 0, 0, 0, 0, 0, 0});
    load_a("rerun", '{1, 1, 1, 1});
    stream_b("rerun", '{1, 1, 1, 1}, '{1, 2, 3, 4, 3, 2, 1});

    repeat (2) begin
      drive(1'b0, 1'b0, 1'b0, 0, 0);
      push("final hold", last_exp);
    end
    repeat (3) @(negedge clk);
    check_val("scoreboard drained", W'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
